// File: rtl/debouncer_if.sv
// Signal bundle between a raw level source and the debouncer.
// The master drives the raw level; the slave returns the clean level and status.
interface debouncer_if;
    logic i_in;
    logic o_out;
    logic o_busy;
    logic o_glitch;

    modport master (
        output i_in,
        input  o_out,
        input  o_busy,
        input  o_glitch
    );

    modport slave (
        input  i_in,
        output o_out,
        output o_busy,
        output o_glitch
    );
endinterface

// File: rtl/debouncer.sv
// Input debouncer: optional synchronizer (DEBOUNCER_SYNC_EN) followed by a stability timer
// that commits a new output level only after P_TIME consecutive matching samples.
module debouncer #(
    parameter int   P_TIME = 16,
    parameter int   P_SYNC = 2,
    parameter logic P_INIT = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    debouncer_if.slave  bus
);
    localparam int               CNT_W    = (P_TIME > 2) ? $clog2(P_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIME - 1);

    typedef enum logic {
        STABLE,
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             glitch_q, glitch_d;
    logic             s;

    generate
        if (P_TIME < 2 || P_SYNC < 2) begin : g_param_check
            $error("debouncer: P_TIME and P_SYNC must both be at least 2");
        end
    endgenerate

    // Stage 0: bring the raw level into the i_clk domain
`ifdef DEBOUNCER_SYNC_EN
    logic [P_SYNC-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {P_SYNC{P_INIT}};
        end else begin
            sync_q <= {sync_q[P_SYNC-2:0], bus.i_in};
        end
    end

    assign s = sync_q[P_SYNC-1];
`else
    assign s = bus.i_in;
`endif

    // Stage 1: stability timer and committed output level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            out_q    <= P_INIT;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (s != out_q) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A bounce back takes priority over a commit on the same edge
                if (s == out_q) begin
                    state_d  = STABLE;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = STABLE;
                    cnt_d    = '0;
                    out_d    = ~out_q;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_out    = out_q;
    assign bus.o_busy   = (state_q == WAIT);
    assign bus.o_glitch = glitch_q;

endmodule
